// File: rtl/sync_ptx.sv
// Source-domain transmitter of a toggle-based pulse synchronizer.
// Turns accepted pulses into out_toggle level flips, one at a time, and queues any that arrive while a flip is unacknowledged.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no toggle in flight; launches on in_pulse or queued pulses
// WAIT_ACK | toggle launched, waiting for synchronized ack to match level

module sync_ptx #(
    parameter int SYNC     = 2,
    parameter int CNT_BITS = 4
) (
    input  logic                in_clock,
    input  logic                in_reset_n,
    input  logic                in_pulse,
    input  logic                ack_toggle,
    input  logic                clear_overflow,
    output logic                out_toggle,
    output logic                busy,
    output logic [CNT_BITS-1:0] pending,
    output logic                overflow
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    localparam logic [CNT_BITS-1:0] PEND_ONE = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] PEND_MAX = '1;

    state_t state;

    (* ASYNC_REG = "TRUE" *) logic [SYNC-1:0] ack_sync;

    logic ack_s;
    logic acked;
    logic pend_nz;
    logic pend_full;

    assign ack_s     = ack_sync[SYNC-1];
    assign acked     = (ack_s == out_toggle);
    assign pend_nz   = (pending != '0);
    assign pend_full = (pending == PEND_MAX);
    assign busy      = (state == WAIT_ACK) || pend_nz;

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state      <= IDLE;
            ack_sync   <= '0;
            out_toggle <= 1'b0;
            pending    <= '0;
            overflow   <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[SYNC-2:0], ack_toggle};

            // A drop in this same cycle below overrides the clear.
            if (clear_overflow) begin
                overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (in_pulse || pend_nz) begin
                        out_toggle <= ~out_toggle;
                        state      <= WAIT_ACK;
                        // Oldest queued pulse goes out; a new pulse takes its slot.
                        if (pend_nz && !in_pulse) begin
                            pending <= pending - PEND_ONE;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (in_pulse) begin
                        if (pend_full) begin
                            overflow <= 1'b1;
                        end else begin
                            pending <= pending + PEND_ONE;
                        end
                    end
                    if (acked) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_ptx.sv
// Directed bench for sync_ptx: a scoreboard of expected out_toggle levels is
// filled as pulses are driven and drained as toggles appear on the output.

module tb_sync_ptx;

    localparam int SYNC     = 2;
    localparam int CNT_BITS = 2;

    logic                in_clock       = 1'b0;
    logic                in_reset_n     = 1'b0;
    logic                in_pulse       = 1'b0;
    logic                clear_overflow = 1'b0;
    logic                loop_en        = 1'b1;
    logic                ack_force      = 1'b0;
    logic                ack_toggle;
    logic                out_toggle;
    logic                busy;
    logic                overflow;
    logic [CNT_BITS-1:0] pending;

    int   tests_run   = 0;
    int   failed      = 0;
    int   cyc         = 0;
    int   toggles     = 0;
    int   last_edge   = -100;
    int   base;
    logic prev_toggle = 1'b0;
    logic exp_level   = 1'b0;
    logic sb[$];

    sync_ptx #(
        .SYNC    (SYNC),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .in_clock      (in_clock),
        .in_reset_n    (in_reset_n),
        .in_pulse      (in_pulse),
        .ack_toggle    (ack_toggle),
        .clear_overflow(clear_overflow),
        .out_toggle    (out_toggle),
        .busy          (busy),
        .pending       (pending),
        .overflow      (overflow)
    );

    assign ack_toggle = loop_en ? out_toggle : ack_force;

    always #5 in_clock = ~in_clock;

    always @(posedge in_clock) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clock);
        #1;
    endtask

    task automatic push_exp();
        exp_level = ~exp_level;
        sb.push_back(exp_level);
    endtask

    task automatic pulse(input bit launches);
        in_pulse = 1'b1;
        if (launches) push_exp();
        tick();
        in_pulse = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    // Output monitor: every level change must match the scoreboard and respect launch spacing.
    always @(negedge in_clock) begin
        if (!in_reset_n) begin
            prev_toggle = 1'b0;
            last_edge   = -100;
        end else if (out_toggle !== prev_toggle) begin
            toggles++;
            check("no_spurious_toggle", sb.size() != 0, 1);
            if (sb.size() != 0) check("toggle_level", out_toggle, sb.pop_front());
            check("launch_spacing", (cyc - last_edge) >= SYNC + 2, 1);
            last_edge   = cyc;
            prev_toggle = out_toggle;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst_out_toggle", out_toggle, 0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        in_reset_n = 1'b1;
        tick();

        // Single pulse with direct loopback
        base = toggles;
        pulse(1);
        check("single_flip", out_toggle, 1);
        check("single_busy", busy, 1);
        check("single_pending", pending, 0);
        tick();
        tick();
        check("single_busy_before_idle", busy, 1);
        tick();
        check("single_idle", busy, 0);
        check("single_count", toggles - base, 1);
        check("single_sb_empty", sb.size(), 0);

        // Burst of three
        base = toggles;
        in_pulse = 1'b1;
        push_exp();
        tick();
        check("burst_pend0", pending, 0);
        push_exp();
        tick();
        check("burst_pend1", pending, 1);
        push_exp();
        tick();
        check("burst_pend2", pending, 2);
        in_pulse = 1'b0;
        wait_idle("burst_drain_timeout");
        check("burst_count", toggles - base, 3);
        check("burst_sb_empty", sb.size(), 0);

        // Overflow with ack held low
        base = toggles;
        loop_en   = 1'b0;
        ack_force = 1'b0;
        pulse(1);
        pulse(1);
        pulse(1);
        pulse(1);
        check("ovf_pend_full", pending, 3);
        check("ovf_not_yet", overflow, 0);
        pulse(0);
        check("ovf_pend_sat", pending, 3);
        check("ovf_set", overflow, 1);
        in_pulse       = 1'b1;
        clear_overflow = 1'b1;
        tick();
        in_pulse       = 1'b0;
        clear_overflow = 1'b0;
        check("ovf_set_beats_clear", overflow, 1);
        check("ovf_pend_hold", pending, 3);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("ovf_cleared", overflow, 0);
        check("ovf_busy_held", busy, 1);
        loop_en = 1'b1;
        wait_idle("ovf_drain_timeout");
        check("ovf_count", toggles - base, 4);
        check("ovf_sb_empty", sb.size(), 0);

        // Pulse in the cycle the ack is seen
        pulse(1);
        tick();
        tick();
        in_pulse = 1'b1;
        push_exp();
        tick();
        in_pulse = 1'b0;
        check("ackcyc_pending", pending, 1);
        check("ackcyc_busy", busy, 1);
        check("ackcyc_level", out_toggle, 1);
        tick();
        check("ackcyc_relaunch", out_toggle, 0);
        check("ackcyc_pend_drained", pending, 0);
        wait_idle("ackcyc_timeout");
        check("ackcyc_sb_empty", sb.size(), 0);

        // Reset in WAIT_ACK with two queued
        loop_en   = 1'b0;
        ack_force = 1'b0;
        pulse(1);
        pulse(0);
        pulse(0);
        check("rstw_pending", pending, 2);
        check("rstw_level", out_toggle, 1);
        #1;
        in_reset_n = 1'b0;
        #1;
        check("rstw_out_toggle", out_toggle, 0);
        check("rstw_pending0", pending, 0);
        check("rstw_busy", busy, 0);
        check("rstw_overflow", overflow, 0);
        sb.delete();
        exp_level = 1'b0;
        tick();
        tick();
        in_reset_n = 1'b1;
        loop_en    = 1'b1;
        base       = toggles;
        repeat (10) tick();
        check("rstw_no_toggle", toggles - base, 0);
        check("rstw_idle", busy, 0);
        pulse(1);
        wait_idle("rstw_new_timeout");
        check("rstw_new_count", toggles - base, 1);
        check("rstw_new_level", out_toggle, 1);
        check("rstw_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
